// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / ID-branch hazard detection,
// in-ID BEQ resolution and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_hold,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [4:0]        id_rs1_id,
    input  logic [4:0]        id_rs2_id,
    input  logic [4:0]        id_rd_id,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic              id_DataEqual,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_is_branch,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic [3:0]        id_ALUOp,
    input  logic [4:0]        mem_rd_id,
    input  logic              mem_MemRead,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rd_id,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc,
    output logic [3:0]        ex_ALUOp,
    output logic              stall,
    output logic              if_flush,
    output logic [ADDR_W-1:0] branch_target,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rd;
        logic              rw;
        logic              mr;
        logic              mw;
        logic              as;
        logic [3:0]        op;
    } ex_t;

    ex_t         r_ex;
    ex_t         w_ex_nxt;
    ex_t         w_id;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_match_ex;
    logic        w_match_mem;
    logic        w_load_use;
    logic        w_br_haz;
    logic        w_haz;
    logic        w_flush;

    function automatic logic f_match(
        input logic [4:0] r,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       u1,
        input logic       u2
    );
        return (r != 5'd0) && ((u1 && r == rs1) || (u2 && r == rs2));
    endfunction

    assign w_match_ex  = f_match(r_ex.rd, id_rs1_id, id_rs2_id,
                                 id_uses_rs1, id_uses_rs2);
    assign w_match_mem = f_match(mem_rd_id, id_rs1_id, id_rs2_id,
                                 id_uses_rs1, id_uses_rs2);

    assign w_load_use = id_valid && r_ex.valid && r_ex.mr && w_match_ex;
    assign w_br_haz   = id_valid && id_is_branch &&
                        ((r_ex.valid && r_ex.rw && w_match_ex) ||
                         (mem_MemRead && w_match_mem));
    assign w_haz      = w_load_use | w_br_haz;
    assign w_flush    = id_valid && id_is_branch && id_DataEqual &&
                        !w_haz && !mem_hold;

    assign w_id = '{valid: 1'b1, pc: id_pc, rs1: id_rs1_data,
                    rs2: id_rs2_data, imm: id_imm, rd: id_rd_id,
                    rw: id_RegWrite, mr: id_MemRead, mw: id_MemWrite,
                    as: id_ALUSrc, op: id_ALUOp};

    // Hold beats bubble beats advance.
    always_comb begin
        w_ex_nxt = r_ex;
        if (mem_hold)
            w_ex_nxt = r_ex;
        else if (w_haz || !id_valid)
            w_ex_nxt = '0;
        else
            w_ex_nxt = w_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ex <= '0;
        else
            r_ex <= w_ex_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_hold) begin
            if (w_haz && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign ex_valid      = r_ex.valid;
    assign ex_pc         = r_ex.pc;
    assign ex_rs1_data   = r_ex.rs1;
    assign ex_rs2_data   = r_ex.rs2;
    assign ex_imm        = r_ex.imm;
    assign ex_rd_id      = r_ex.rd;
    assign ex_RegWrite   = r_ex.rw;
    assign ex_MemRead    = r_ex.mr;
    assign ex_MemWrite   = r_ex.mw;
    assign ex_ALUSrc     = r_ex.as;
    assign ex_ALUOp      = r_ex.op;
    assign stall         = w_haz | mem_hold;
    assign if_flush      = w_flush;
    assign branch_target = id_pc + ADDR_W'(id_imm);
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use, x0, BEQ, branch after
// load, mem_hold freeze and stall counter saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_hold;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [4:0]  id_rs1_id, id_rs2_id, id_rd_id;
    logic        id_uses_rs1, id_uses_rs2;
    logic [63:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_DataEqual, id_is_branch;
    logic        id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc;
    logic [3:0]  id_ALUOp;
    logic [4:0]  mem_rd_id;
    logic        mem_MemRead;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd_id;
    logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc;
    logic [3:0]  ex_ALUOp;
    logic        stall, if_flush;
    logic [63:0] branch_target;
    logic [31:0] stall_cnt, flush_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .mem_hold(mem_hold),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
        .id_rd_id(id_rd_id), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_DataEqual(id_DataEqual),
        .id_imm(id_imm), .id_is_branch(id_is_branch),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
        .id_ALUOp(id_ALUOp), .mem_rd_id(mem_rd_id),
        .mem_MemRead(mem_MemRead), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rd_id(ex_rd_id), .ex_RegWrite(ex_RegWrite),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
        .stall(stall), .if_flush(if_flush),
        .branch_target(branch_target),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic id_idle();
        id_valid = 0; id_pc = 0; id_rs1_id = 0; id_rs2_id = 0;
        id_rd_id = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_DataEqual = 0; id_is_branch = 0; id_RegWrite = 0;
        id_MemRead = 0; id_MemWrite = 0; id_ALUSrc = 0; id_ALUOp = 0;
    endtask

    task automatic id_ld(input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [63:0] pc);
        id_idle();
        id_valid = 1; id_pc = pc; id_rd_id = rd; id_rs1_id = rs1;
        id_uses_rs1 = 1; id_RegWrite = 1; id_MemRead = 1;
        id_ALUSrc = 1; id_imm = 64'h10; id_rs1_data = 64'h2000;
    endtask

    task automatic id_alu(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [63:0] pc);
        id_idle();
        id_valid = 1; id_pc = pc; id_rd_id = rd;
        id_rs1_id = rs1; id_rs2_id = rs2;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_RegWrite = 1;
        id_ALUOp = 4'h2; id_rs1_data = 64'h1111; id_rs2_data = 64'h2222;
    endtask

    task automatic id_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [63:0] pc, input logic [63:0] imm);
        id_idle();
        id_valid = 1; id_pc = pc; id_rs1_id = rs1; id_rs2_id = rs2;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_is_branch = 1;
        id_DataEqual = 1; id_imm = imm; id_ALUOp = 4'h1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; mem_hold = 0; mem_rd_id = 0; mem_MemRead = 0;
        id_idle();
        #12 rst_n = 1;
        @(negedge clk);

        // reset asserted mid-cycle clears registered state at once
        id_alu(5'd3, 5'd8, 5'd9, 64'h40);
        tick();
        check("pre_rst_valid", 64'(ex_valid), 64'd1);
        check("pre_rst_pc", ex_pc, 64'h40);
        #2 rst_n = 0;
        #1;
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_pc", ex_pc, 64'd0);
        check("rst_rs1", ex_rs1_data, 64'd0);
        check("rst_rd", 64'(ex_rd_id), 64'd0);
        check("rst_rw_op", {59'd0, ex_RegWrite, ex_ALUOp}, 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        id_idle();
        @(negedge clk);
        rst_n = 1;

        // load-use: ld x5 then add x6,x5,x7
        id_ld(5'd5, 5'd2, 64'h200);
        tick();
        id_alu(5'd6, 5'd5, 5'd7, 64'h204);
        #1;
        check("lu_stall", 64'(stall), 64'd1);
        tick();
        check("lu_bubble", 64'(ex_valid), 64'd0);
        check("lu_bubble_rd", 64'(ex_rd_id), 64'd0);
        check("lu_stall_drop", 64'(stall), 64'd0);
        check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
        tick();
        check("lu_add_valid", 64'(ex_valid), 64'd1);
        check("lu_add_rd", 64'(ex_rd_id), 64'd6);
        check("lu_add_rs1", ex_rs1_data, 64'h1111);

        // x0 never hazards
        id_ld(5'd0, 5'd2, 64'h300);
        tick();
        id_alu(5'd9, 5'd0, 5'd0, 64'h304);
        #1;
        check("x0_stall", 64'(stall), 64'd0);
        tick();
        check("x0_adv", 64'(ex_pc), 64'h304);
        check("x0_stall_cnt", 64'(stall_cnt), 64'd1);

        // taken branch, no hazard
        id_beq(5'd1, 5'd2, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8);
        #1;
        check("br_flush", 64'(if_flush), 64'd1);
        check("br_target", branch_target, 64'hF8);
        check("br_stall", 64'(stall), 64'd0);
        tick();
        check("br_flush_cnt", 64'(flush_cnt), 64'd1);
        check("br_ex_pc", ex_pc, 64'h100);
        check("br_ex_rw", 64'(ex_RegWrite), 64'd0);

        // branch depending on a load: two stall cycles
        id_ld(5'd1, 5'd4, 64'h400);
        tick();
        id_beq(5'd1, 5'd2, 64'h404, 64'h20);
        #1;
        check("bl_stall1", 64'(stall), 64'd1);
        check("bl_noflush1", 64'(if_flush), 64'd0);
        tick();
        mem_rd_id = 5'd1; mem_MemRead = 1;
        #1;
        check("bl_bubble", 64'(ex_valid), 64'd0);
        check("bl_stall2", 64'(stall), 64'd1);
        check("bl_noflush2", 64'(if_flush), 64'd0);
        tick();
        mem_rd_id = 5'd0; mem_MemRead = 0;
        #1;
        check("bl_stall3", 64'(stall), 64'd0);
        check("bl_flush", 64'(if_flush), 64'd1);
        check("bl_target", branch_target, 64'h424);
        tick();
        check("bl_stall_cnt", 64'(stall_cnt), 64'd3);
        check("bl_flush_cnt", 64'(flush_cnt), 64'd2);

        // mem_hold during a load-use freezes everything
        id_ld(5'd5, 5'd2, 64'h500);
        tick();
        id_alu(5'd6, 5'd5, 5'd7, 64'h504);
        mem_hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mh_valid", 64'(ex_valid), 64'd1);
            check("mh_pc", ex_pc, 64'h500);
            check("mh_stall_cnt", 64'(stall_cnt), 64'd3);
        end
        mem_hold = 0;
        #1;
        check("mh_rel_stall", 64'(stall), 64'd1);
        tick();
        check("mh_bubble", 64'(ex_valid), 64'd0);
        check("mh_stall_cnt2", 64'(stall_cnt), 64'd4);
        tick();
        check("mh_add_pc", ex_pc, 64'h504);

        // stall counter saturates
        id_ld(5'd5, 5'd2, 64'h600);
        tick();
        id_alu(5'd6, 5'd5, 5'd7, 64'h604);
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.r_stall_cnt;
        #1;
        check("sat_cnt", 64'(stall_cnt), 64'hFFFF_FFFF);
        check("sat_bubble", 64'(ex_valid), 64'd0);
        id_idle();
        tick();
        check("sat_hold", 64'(stall_cnt), 64'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
